// File: rtl/core_seq_pkg.sv
// ============================================================================
// Module      : core_seq_pkg
// Description : Shared types and defaults for the core run sequencer.
//               Provides the 2-bit sequencer state enum and the default
//               terminating PC value and clear-phase length.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int DEF_END_ADDR = 128;
  localparam int DEF_CLR_CYC  = 2;

endpackage : core_seq_pkg

`default_nettype wire

// File: rtl/core_sequencer_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter that sticks at all-ones instead of wrapping.
//               Synchronous clear has priority over increment.
// Ports       : clk    in  1  clock
//               rst_n  in  1  asynchronous active-low reset (q -> 0)
//               clr    in  1  synchronous clear
//               inc    in  1  increment request (ignored at all-ones)
//               q      out W  count value
//               at_max out 1  count is all-ones
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         at_max
);

  logic [W-1:0] q_q;

  assign q      = q_q;
  assign at_max = &q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (inc && !at_max) begin
      q_q <= q_q + 1'b1;
    end
  end

endmodule : sat_counter

`default_nettype wire

// File: rtl/core_sequencer.sv
// ============================================================================
// Module      : core_sequencer
// Description : Run controller for the single-cycle core. A high req level
//               holds the core in reset for CLR_CYC cycles, then enables it
//               until the PC reaches END_ADDR or a halt is decoded; done is
//               then held until req drops. cycle_cnt reports the number of
//               enabled RUN cycles (saturating).
//               Optional feature macro: CORE_SEQ_WDOG_EN enables a watchdog
//               that ends a run after MAX_CYC counted cycles with timeout=1.
// Ports       : clk       in  1   core clock
//               reset     in  1   asynchronous active-low reset
//               req       in  1   run request level (0 = idle/abort)
//               prog_ctr  in  D   current PC
//               halt      in  1   decoded halt, meaningful in RUN
//               core_rst  out 1   synchronous reset to PC/regs/flags
//               core_en   out 1   advance/write enable (combinational)
//               busy      out 1   clearing or running
//               done      out 1   run finished, held until req drops
//               timeout   out 1   run ended by watchdog
//               cycle_cnt out CW  enabled RUN cycles of current/last run
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int D        = 12,
  parameter int END_ADDR = DEF_END_ADDR,
  parameter int CLR_CYC  = DEF_CLR_CYC,
  parameter int CW       = 16,
  parameter int MAX_CYC  = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  prog_ctr,
  input  logic          halt,
  output logic          core_rst,
  output logic          core_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  // clr_cnt only ever holds CLR_CYC-1 down to 0.
  localparam int               CLRW     = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CLRW-1:0]  CLR_LOAD = CLRW'(CLR_CYC - 1);

`ifdef CORE_SEQ_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  seq_state_t      state_q, state_d;
  logic [CLRW-1:0] clr_cnt_q, clr_cnt_d;
  logic            core_rst_q, busy_q, done_q;
  logic            stop;
  logic            wdog_hit;
  logic            cnt_clr, cnt_inc, cnt_at_max;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    stop      = (prog_ctr == D'(END_ADDR)) | halt;
    wdog_hit  = WDOG_EN && (cycle_cnt == CW'(MAX_CYC));
    // PC must freeze on the stop address, so enable drops in the stop cycle.
    core_en   = (state_q == ST_RUN) & ~stop;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d   = ST_CLR;
          clr_cnt_d = CLR_LOAD;
          cnt_clr   = 1'b1;
        end
      end
      ST_CLR: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (clr_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        // Abort has priority over a simultaneous stop.
        if (!req) begin
          state_d = ST_IDLE;
        end else if (stop || wdog_hit) begin
          state_d = ST_DONE;
        end else begin
          cnt_inc = ~cnt_at_max;
        end
      end
      ST_DONE: begin
        if (!req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      core_rst_q <= (state_d == ST_IDLE) || (state_d == ST_CLR);
      busy_q     <= (state_d == ST_CLR)  || (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign core_rst = core_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef CORE_SEQ_WDOG_EN
  logic timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else if (cnt_clr) begin
      timeout_q <= 1'b0;
    end else if ((state_q == ST_RUN) && req && !stop && wdog_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  sat_counter #(
    .W (CW)
  ) u_cycle_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .q      (cycle_cnt),
    .at_max (cnt_at_max)
  );

endmodule : core_sequencer

`default_nettype wire
